// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the BRAM stream reader.
package bram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // Only read latency the credit accounting is built for.
    localparam int unsigned MEM_DELAY_SUPPORTED = 2;

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// Return buffer: small synchronous FIFO, write and read allowed in the same cycle.
module bram_rd_fifo
    import bram_stream_reader_pkg::*;
#(
    parameter int unsigned DAT_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en_i,
    input  logic [DAT_WIDTH-1:0]               wr_dat_i,
    input  logic                               rd_en_i,
    output logic [DAT_WIDTH-1:0]               rd_dat_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o,
    output logic                               empty_o,
    output logic                               full_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DAT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 wr_ok;
    logic                 rd_ok;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == CNT_W'(FIFO_DEPTH));
    assign count_o  = count_q;
    assign rd_dat_o = mem_q[rd_ptr_q];

    // A read in the same cycle frees the slot a write into a full FIFO needs.
    assign rd_ok = rd_en_i && !empty_o;
    assign wr_ok = wr_en_i && (!full_o || rd_ok);

    // Storage array; cleared on reset so the stream data output starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Sequential BRAM read engine: credit-limited read issue, return buffer, valid/ready stream out.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int unsigned DAT_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned ADDR_STEP  = 1,
    parameter int unsigned MEM_DELAY  = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic                  m_rden_o,
    input  logic [DAT_WIDTH-1:0]  m_odat_i,
    input  logic                  m_oval_i,
    output logic [DAT_WIDTH-1:0]  out_dat_o,
    output logic                  out_val_o,
    input  logic                  out_rdy_i
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    if (MEM_DELAY != MEM_DELAY_SUPPORTED || FIFO_DEPTH < MEM_DELAY + 2) begin : g_param_check
        $error("bram_stream_reader: unsupported MEM_DELAY or FIFO_DEPTH");
    end

    rd_state_e             state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  m_rden_q;
    logic [ADDR_WIDTH-1:0] m_addr_q;
    logic [ADDR_WIDTH-1:0] next_addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  sched_cnt_q;
    logic [LEN_WIDTH-1:0]  out_cnt_q;
    logic [CNT_W-1:0]      inflight_q;
    logic [CNT_W-1:0]      inflight_d;
    logic [CNT_W-1:0]      fifo_count_d;

    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  unused_fifo_full;   // never reached without a read: credits cap occupancy
    logic                  fifo_wr;
    logic                  fifo_rd;
    logic                  credit_ok;

    // Returns with nothing outstanding (e.g. after a reset) are stale and dropped.
    assign fifo_wr = m_oval_i && (inflight_q != '0);
    assign fifo_rd = out_val_o && out_rdy_i;

    bram_rd_fifo #(
        .DAT_WIDTH  (DAT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (fifo_wr),
        .wr_dat_i (m_odat_i),
        .rd_en_i  (out_rdy_i),
        .rd_dat_o (out_dat_o),
        .count_o  (fifo_count),
        .empty_o  (fifo_empty),
        .full_o   (unused_fifo_full)
    );

    assign out_val_o = !fifo_empty;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign m_rden_o  = m_rden_q;
    assign m_addr_o  = m_addr_q;

    // Next-cycle credit: a read may be scheduled only if buffer + outstanding stays below depth.
    always_comb begin
        inflight_d = inflight_q;
        if (m_rden_q && !fifo_wr) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!m_rden_q && fifo_wr) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
        fifo_count_d = fifo_count;
        if (fifo_wr && !fifo_rd) begin
            fifo_count_d = fifo_count + CNT_W'(1);
        end else if (!fifo_wr && fifo_rd) begin
            fifo_count_d = fifo_count - CNT_W'(1);
        end
        credit_ok = (SUM_W'(fifo_count_d) + SUM_W'(inflight_d)) < SUM_W'(FIFO_DEPTH);
    end

    // Outstanding-read counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    // Control FSM, address generator and registered status/issue outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            m_rden_q    <= 1'b0;
            m_addr_q    <= '0;
            next_addr_q <= '0;
            len_q       <= '0;
            sched_cnt_q <= '0;
            out_cnt_q   <= '0;
        end else begin
            done_q   <= 1'b0;
            m_rden_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (len_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            // Buffer is empty and nothing is outstanding, so the first read needs no credit check.
                            busy_q      <= 1'b1;
                            len_q       <= len_i;
                            sched_cnt_q <= LEN_WIDTH'(1);
                            out_cnt_q   <= '0;
                            m_rden_q    <= 1'b1;
                            m_addr_q    <= base_addr_i;
                            next_addr_q <= base_addr_i + ADDR_WIDTH'(ADDR_STEP);
                            state_q     <= (len_i == LEN_WIDTH'(1)) ? ST_DRAIN : ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (credit_ok) begin
                        m_rden_q    <= 1'b1;
                        m_addr_q    <= next_addr_q;
                        next_addr_q <= next_addr_q + ADDR_WIDTH'(ADDR_STEP);
                        sched_cnt_q <= sched_cnt_q + LEN_WIDTH'(1);
                        if (sched_cnt_q + LEN_WIDTH'(1) == len_q) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                    if (fifo_rd) begin
                        out_cnt_q <= out_cnt_q + LEN_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    if (fifo_rd) begin
                        out_cnt_q <= out_cnt_q + LEN_WIDTH'(1);
                        if (out_cnt_q == len_q - LEN_WIDTH'(1)) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader with a 2-cycle BRAM model returning data = address.
module tb_bram_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [31:0] m_addr;
    logic        m_rden;
    logic [31:0] m_odat;
    logic        m_oval;
    logic [31:0] out_dat;
    logic        out_val;
    logic        out_rdy;

    bram_stream_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .base_addr_i (base_addr),
        .len_i       (len),
        .busy_o      (busy),
        .done_o      (done),
        .m_addr_o    (m_addr),
        .m_rden_o    (m_rden),
        .m_odat_i    (m_odat),
        .m_oval_i    (m_oval),
        .out_dat_o   (out_dat),
        .out_val_o   (out_val),
        .out_rdy_i   (out_rdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: not reset, so reads in flight at a reset still come back.
    logic        p1_v = 1'b0, p2_v = 1'b0;
    logic [31:0] p1_a = '0,   p2_a = '0;
    always @(posedge clk) begin
        p1_v <= m_rden;
        p1_a <= m_addr;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end
    assign m_oval = p2_v;
    assign m_odat = p2_a;

    int checks   = 0;
    int failures = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name, input string what);
        checks++;
        failures++;
        $display("FAIL %s: %s", name, what);
    endfunction

    logic [31:0] exp_addr[$];
    logic [31:0] exp_dat[$];

    int rden_count, first_rden, last_rden, first_val, first_busy, done_count, done_cyc;
    logic        hold_q   = 1'b0;
    logic [31:0] held_dat = '0;

    // Monitor: pops the scoreboard on every issued read and every stream handshake.
    always @(negedge clk) begin
        if (rst) begin
            hold_q = 1'b0;
        end else begin
            if (m_rden) begin
                rden_count++;
                if (first_rden < 0) first_rden = cyc;
                last_rden = cyc;
                if (exp_addr.size() == 0) fail_now("m_addr", "read issued with no address expected");
                else check("m_addr", longint'(m_addr), longint'(exp_addr.pop_front()));
            end
            if (hold_q) begin
                check("out_val_held", longint'(out_val), 1);
                check("out_dat_stable", longint'(out_dat), longint'(held_dat));
            end
            if (out_val && first_val < 0) first_val = cyc;
            if (out_val && out_rdy) begin
                if (exp_dat.size() == 0) fail_now("out_dat", "handshake with no data expected");
                else check("out_dat", longint'(out_dat), longint'(exp_dat.pop_front()));
            end
            if (busy && first_busy < 0) first_busy = cyc;
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            hold_q   = out_val && !out_rdy;
            held_dat = out_dat;
        end
    end

    task automatic clear_stats();
        rden_count = 0; first_rden = -1; last_rden = -1; first_val = -1;
        first_busy = -1; done_count = 0; done_cyc = -1;
    endtask

    // Called just after a rising edge; returns one cycle later with start dropped.
    task automatic start_xfer(input logic [31:0] b, input logic [15:0] n, output int t);
        for (int i = 0; i < int'(n); i++) begin
            exp_addr.push_back(b + 32'(i));
            exp_dat.push_back(b + 32'(i));
        end
        start = 1'b1; base_addr = b; len = n; t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (done_count < 1 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (done_count < 1) fail_now(name, "done not seen within cycle budget");
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},    longint'(busy),    0);
        check({tag, "_done"},    longint'(done),    0);
        check({tag, "_m_rden"},  longint'(m_rden),  0);
        check({tag, "_m_addr"},  longint'(m_addr),  0);
        check({tag, "_out_val"}, longint'(out_val), 0);
        check({tag, "_out_dat"}, longint'(out_dat), 0);
    endtask

    initial begin
        int t;
        rst = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_rdy = 1'b0;
        clear_stats();
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic streaming with out_rdy held high.
        clear_stats(); out_rdy = 1'b1;
        start_xfer(32'h10, 16'd8, t);
        wait_done(50, "t1_done");
        check("t1_first_busy", first_busy, t + 1);
        check("t1_first_rden", first_rden, t + 1);
        check("t1_last_rden",  last_rden,  t + 8);
        check("t1_rden_count", rden_count, 8);
        check("t1_first_val",  first_val,  t + 4);
        check("t1_done_cyc",   done_cyc,   t + 12);
        check("t1_sb_left",    exp_dat.size(), 0);
        check("t1_busy_after", longint'(busy), 0);

        // Backpressure: credits must stop issue at exactly the buffer depth.
        repeat (2) @(posedge clk); #1;
        clear_stats(); out_rdy = 1'b0;
        start_xfer(32'h100, 16'd16, t);
        repeat (9) @(posedge clk); #1;
        check("t2_rden_stalled", rden_count, 4);
        out_rdy = 1'b1;
        wait_done(100, "t2_done");
        check("t2_rden_count", rden_count, 16);
        check("t2_sb_left",    exp_dat.size(), 0);

        // Zero-length command.
        repeat (2) @(posedge clk); #1;
        clear_stats();
        start_xfer(32'h40, 16'd0, t);
        repeat (5) @(posedge clk); #1;
        check("t3_done_count", done_count, 1);
        check("t3_done_cyc",   done_cyc,   t + 1);
        check("t3_rden_count", rden_count, 0);
        check("t3_busy_never", first_busy, -1);

        // Address wrap-around.
        clear_stats();
        start_xfer(32'hFFFF_FFFE, 16'd4, t);
        wait_done(50, "t4_done");
        check("t4_rden_count", rden_count, 4);
        check("t4_sb_left",    exp_dat.size(), 0);

        // Reset with two reads outstanding, then a fresh transfer.
        repeat (2) @(posedge clk); #1;
        clear_stats();
        start_xfer(32'h200, 16'd8, t);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_outputs_zero("t5_async_reset");
        #1 rst = 1'b0;
        exp_addr.delete();
        exp_dat.delete();
        repeat (4) @(posedge clk); #1;
        check("t5_stale_dropped", longint'(out_val), 0);
        clear_stats();
        start_xfer(32'h300, 16'd3, t);
        wait_done(50, "t5_done");
        check("t5_first_val", first_val, t + 4);
        check("t5_done_cyc",  done_cyc,  t + 7);
        check("t5_sb_left",   exp_dat.size(), 0);

        // Random backpressure with stray start pulses while busy.
        repeat (2) @(posedge clk); #1;
        clear_stats();
        start_xfer(32'h1000, 16'd100, t);
        for (int k = 0; k < 3000 && done_count < 1; k++) begin
            out_rdy = 1'($urandom_range(0, 1));
            if (busy && (k % 17 == 5)) begin
                start = 1'b1; base_addr = 32'hABC; len = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (done_count < 1) fail_now("t6_done", "done not seen within cycle budget");
        out_rdy = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("t6_done_count", done_count, 1);
        check("t6_rden_count", rden_count, 100);
        check("t6_sb_left",    exp_dat.size(), 0);
        check("t6_addr_left",  exp_addr.size(), 0);
        check("t6_busy_after", longint'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
